// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
// Turns CPU load/store requests (byte/half/word/dword, either endianness) into
// aligned full-width memory transactions with per-byte strobes, waits for
// mem_ack under a bus-timeout counter, and returns a formatted load result.
// Optional LL/SC reservation tracking is compiled in with MEM_ACCESS_LLSC_EN.
//
// Handshake: cpu_req is held, with every cpu_* input stable, until the
// one-cycle cpu_done pulse; cpu_req is only sampled in IDLE. mem_req is held
// from the cycle after acceptance until mem_ack (or timeout), and mem_ack is
// honoured only while the unit is waiting for it.
module mem_access_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [1:0]          cpu_size,
  input  logic                cpu_sign,
  input  logic                cpu_be,
  input  logic                cpu_llsc,
  input  logic                clear_resv,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_done,
  output logic                cpu_adel,
  output logic                cpu_ades,
  output logic                cpu_buserr,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  state_t state, state_next;

  logic [OFF_W-1:0]  off;
  logic [3:0]        n_bytes;
  logic              addr_err;
  logic [OFF_W-1:0]  lane_lo;
  logic [NB-1:0]     lane_mask;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] shifted;
  logic              load_msb;
  logic [DATA_W-1:0] load_val;
  logic              is_sc;
  logic              sc_fail;
  logic              timeout_hit;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              adel_q;
  logic              ades_q;
  logic              buserr_q;

  // Request decode: lane selection, alignment check, store replication and
  // load formatting. The cpu_* inputs are stable for the whole transaction, so
  // the same decode serves both acceptance in IDLE and capture on mem_ack.
  always_comb begin
    off      = cpu_addr[OFF_W-1:0];
    n_bytes  = 4'd1 << cpu_size;
    addr_err = ((int'(off) & (int'(n_bytes) - 1)) != 0) || (int'(n_bytes) > NB);
    lane_lo  = cpu_be ? OFF_W'(NB - int'(off) - int'(n_bytes)) : off;
    for (int i = 0; i < NB; i++) begin
      lane_mask[i]        = (i >= int'(lane_lo)) && (i < int'(lane_lo) + int'(n_bytes));
      wdata_rep[8*i +: 8] = cpu_wdata[8*(i & (int'(n_bytes) - 1)) +: 8];
    end
    shifted  = mem_rdata >> {lane_lo, 3'b000};
    load_msb = 1'b0;
    for (int b = 0; b < DATA_W; b++) begin
      if (b == 8*int'(n_bytes) - 1) load_msb = shifted[b];
    end
    for (int b = 0; b < DATA_W; b++) begin
      load_val[b] = (b < 8*int'(n_bytes)) ? shifted[b] : (cpu_sign & load_msb);
    end
  end

  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);

`ifdef MEM_ACCESS_LLSC_EN
  logic                    resv_valid;
  logic [ADDR_W-OFF_W-1:0] resv_line;
  logic                    line_match;

  assign line_match = (resv_line == cpu_addr[ADDR_W-1:OFF_W]);
  assign is_sc      = cpu_we & cpu_llsc;
  assign sc_fail    = is_sc & ~(resv_valid & line_match);

  // Reservation: set by an acked LL; cleared by ERET (highest priority), by an
  // acked store to the reserved line (covers a successful SC), or by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      resv_valid <= 1'b0;
      resv_line  <= '0;
    end else if (clear_resv) begin
      resv_valid <= 1'b0;
    end else if (state == WAIT && mem_ack) begin
      if (cpu_we) begin
        if (line_match) resv_valid <= 1'b0;
      end else if (cpu_llsc) begin
        resv_valid <= 1'b1;
        resv_line  <= cpu_addr[ADDR_W-1:OFF_W];
      end
    end
  end
`else
  logic unused_llsc;
  assign unused_llsc = clear_resv | cpu_llsc;
  assign is_sc       = 1'b0;
  assign sc_fail     = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state: errors and failed SCs skip the bus entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cpu_req) state_next = (addr_err || sc_fail) ? RESP : WAIT;
      WAIT:    if (mem_ack || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus request registers, timeout counter and the result held for RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      adel_q    <= 1'b0;
      ades_q    <= 1'b0;
      buserr_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (cpu_req) begin
            rdata_q  <= '0;
            adel_q   <= addr_err & ~cpu_we;
            ades_q   <= addr_err & cpu_we;
            buserr_q <= 1'b0;
            if (!addr_err && !sc_fail) begin
              mem_req   <= 1'b1;
              mem_we    <= cpu_we;
              mem_addr  <= {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_wstrb <= cpu_we ? lane_mask : '0;
              mem_wdata <= wdata_rep;
            end
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            rdata_q <= cpu_we ? DATA_W'(is_sc) : load_val;
          end else if (timeout_hit) begin
            mem_req  <= 1'b0;
            buserr_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_done   = (state == RESP);
  assign cpu_rdata  = cpu_done ? rdata_q : '0;
  assign cpu_adel   = cpu_done & adel_q;
  assign cpu_ades   = cpu_done & ades_q;
  assign cpu_buserr = cpu_done & buserr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit. Two instances (32-bit
// bus with a 4-cycle timeout, 64-bit bus with the default timeout) share the
// stimulus; sel routes cpu_req/mem_ack to one of them. A transaction-level
// model sets the expected outputs cycle by cycle and one compare process checks
// the selected instance on every falling edge.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_LLSC_EN
  localparam bit LLSC = 1'b1;
`else
  localparam bit LLSC = 1'b0;
`endif

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  // shared stimulus
  logic        sel;
  logic        cpu_req, cpu_we, cpu_sign, cpu_be, cpu_llsc, clear_resv, mem_ack;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [63:0] cpu_wdata, mem_rdata;

  // 32-bit instance outputs
  logic [31:0] rdata_a, maddr_a, wdata_a;
  logic [3:0]  strb_a;
  logic        done_a, adel_a, ades_a, berr_a, mreq_a, mwe_a;
  // 64-bit instance outputs
  logic [63:0] rdata_b, wdata_b;
  logic [31:0] maddr_b;
  logic [7:0]  strb_b;
  logic        done_b, adel_b, ades_b, berr_b, mreq_b, mwe_b;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(4)) u_d32 (
    .clock(clock), .reset(reset), .cpu_req(cpu_req & ~sel), .cpu_we(cpu_we),
    .cpu_size(cpu_size), .cpu_sign(cpu_sign), .cpu_be(cpu_be), .cpu_llsc(cpu_llsc),
    .clear_resv(clear_resv), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata[31:0]),
    .cpu_rdata(rdata_a), .cpu_done(done_a), .cpu_adel(adel_a), .cpu_ades(ades_a),
    .cpu_buserr(berr_a), .mem_req(mreq_a), .mem_we(mwe_a), .mem_addr(maddr_a),
    .mem_wstrb(strb_a), .mem_wdata(wdata_a), .mem_rdata(mem_rdata[31:0]),
    .mem_ack(mem_ack & ~sel)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYC(16)) u_d64 (
    .clock(clock), .reset(reset), .cpu_req(cpu_req & sel), .cpu_we(cpu_we),
    .cpu_size(cpu_size), .cpu_sign(cpu_sign), .cpu_be(cpu_be), .cpu_llsc(cpu_llsc),
    .clear_resv(clear_resv), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(rdata_b), .cpu_done(done_b), .cpu_adel(adel_b), .cpu_ades(ades_b),
    .cpu_buserr(berr_b), .mem_req(mreq_b), .mem_we(mwe_b), .mem_addr(maddr_b),
    .mem_wstrb(strb_b), .mem_wdata(wdata_b), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack & sel)
  );

  // scoreboard counters
  int vectors     = 0;
  int miscompares = 0;

  // model: expected outputs of the selected instance for the current cycle
  logic        chk_en = 1'b0;
  logic        exp_mreq, exp_we, exp_done, exp_adel, exp_ades, exp_berr;
  logic [63:0] exp_addr, exp_strb, exp_wdata, exp_rdata;
  logic        resv_v = 1'b0;
  logic [31:0] resv_line = '0;
  logic        clr_at_ack = 1'b0;

  // observations captured by the compare process, used by literal checks
  logic [63:0] obs_addr, obs_strb, obs_wdata, obs_rdata;
  logic        obs_adel, obs_ades, obs_berr;
  int          req_cycles;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    exp_mreq = 0; exp_we = 0; exp_done = 0; exp_adel = 0; exp_ades = 0; exp_berr = 0;
    exp_addr = '0; exp_strb = '0; exp_wdata = '0; exp_rdata = '0;
  endtask

  // compare process: selected instance against the model, every cycle
  logic        a_mreq, a_we, a_done, a_adel, a_ades, a_berr;
  logic [63:0] a_addr, a_strb, a_wdata, a_rdata;
  always @(negedge clock) begin
    if (chk_en) begin
      a_mreq  = sel ? mreq_b : mreq_a;
      a_we    = sel ? mwe_b  : mwe_a;
      a_done  = sel ? done_b : done_a;
      a_adel  = sel ? adel_b : adel_a;
      a_ades  = sel ? ades_b : ades_a;
      a_berr  = sel ? berr_b : berr_a;
      a_addr  = sel ? 64'(maddr_b) : 64'(maddr_a);
      a_strb  = sel ? 64'(strb_b)  : 64'(strb_a);
      a_wdata = sel ? wdata_b : 64'(wdata_a);
      a_rdata = sel ? rdata_b : 64'(rdata_a);
      chk("mem_req",    64'(a_mreq), 64'(exp_mreq));
      chk("cpu_done",   64'(a_done), 64'(exp_done));
      chk("cpu_rdata",  a_rdata,     exp_rdata);
      chk("cpu_adel",   64'(a_adel), 64'(exp_adel));
      chk("cpu_ades",   64'(a_ades), 64'(exp_ades));
      chk("cpu_buserr", 64'(a_berr), 64'(exp_berr));
      if (exp_mreq) begin
        chk("mem_we",    64'(a_we), 64'(exp_we));
        chk("mem_addr",  a_addr,    exp_addr);
        chk("mem_wstrb", a_strb,    exp_strb);
        chk("mem_wdata", a_wdata,   exp_wdata);
      end
      if (a_mreq) begin
        req_cycles++;
        obs_addr = a_addr; obs_strb = a_strb; obs_wdata = a_wdata;
      end
      if (a_done) begin
        obs_rdata = a_rdata; obs_adel = a_adel; obs_ades = a_ades; obs_berr = a_berr;
      end
    end
  end

  // driver + model for one CPU transaction; ack_at = WAIT cycle carrying
  // mem_ack (0 = never). Entered and left just after a rising edge, unit idle.
  task automatic txn(input logic s, input logic we, input logic [1:0] size, input logic sign,
                     input logic be, input logic llsc, input logic [31:0] addr,
                     input logic [63:0] wd, input int ack_at, input logic [63:0] rd);
    int nb, tmo, n, off, lo;
    logic err, is_sc, sc_ok;
    logic [63:0] val, nmask, fmask;
    logic [31:0] line;
    sel = s; cpu_we = we; cpu_size = size; cpu_sign = sign; cpu_be = be;
    cpu_llsc = llsc; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    obs_addr = '1; obs_strb = '1; obs_wdata = '1; obs_rdata = '1;
    obs_adel = 1'b0; obs_ades = 1'b0; obs_berr = 1'b0; req_cycles = 0;
    @(posedge clock); #1;
    nb    = s ? 8 : 4;
    tmo   = s ? 16 : 4;
    n     = 1 << size;
    off   = int'(addr % nb);
    err   = (off % n != 0) || (n > nb);
    lo    = be ? nb - off - n : off;
    line  = addr / nb;
    is_sc = LLSC && we && llsc;
    sc_ok = resv_v && (resv_line == line);
    if (err) begin
      exp_done = 1; exp_adel = !we; exp_ades = we;
    end else if (is_sc && !sc_ok) begin
      exp_done = 1;
    end else begin
      exp_mreq = 1; exp_we = we; exp_addr = 64'(addr) - 64'(off);
      exp_strb = '0; exp_wdata = '0;
      for (int i = 0; i < nb; i++) begin
        if (we && i >= lo && i < lo + n) exp_strb[i] = 1'b1;
        exp_wdata[8*i +: 8] = wd[8*(i % n) +: 8];
      end
      for (int j = 1; j <= 64; j++) begin
        if (j == ack_at) begin
          mem_ack = 1; mem_rdata = rd;
          if (clr_at_ack) clear_resv = 1;
        end
        @(posedge clock); #1;
        mem_ack = 0; clear_resv = 0;
        if (j == ack_at) begin
          exp_mreq = 0; exp_done = 1;
          if (we) begin
            exp_rdata = is_sc ? 64'd1 : 64'd0;
          end else begin
            fmask = (nb == 8) ? '1 : 64'hFFFF_FFFF;
            nmask = (n == 8) ? '1 : ((64'd1 << (8*n)) - 64'd1);
            val   = (rd >> (8*lo)) & nmask;
            if (sign && val[8*n-1]) val = val | ~nmask;
            exp_rdata = val & fmask;
          end
          if (LLSC) begin
            if (clr_at_ack) resv_v = 0;
            else if (we && resv_v && resv_line == line) resv_v = 0;
            else if (!we && llsc) begin resv_v = 1; resv_line = line; end
          end
          break;
        end
        if (j == tmo) begin
          exp_mreq = 0; exp_done = 1; exp_berr = 1;
          break;
        end
      end
    end
    cpu_req = 1'b0;
    @(posedge clock); #1;
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected end before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; sel = 0; cpu_req = 0; cpu_we = 0; cpu_sign = 0; cpu_be = 0; cpu_llsc = 0;
    clear_resv = 0; mem_ack = 0; cpu_size = 0; cpu_addr = 0; cpu_wdata = 0; mem_rdata = 0;
    set_idle();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_mem_req_32",  64'(mreq_a), 0);
    chk("rst_mem_addr_32", 64'(maddr_a), 0);
    chk("rst_wstrb_32",    64'(strb_a), 0);
    chk("rst_done_32",     64'(done_a), 0);
    chk("rst_rdata_32",    64'(rdata_a), 0);
    chk("rst_mem_req_64",  64'(mreq_b), 0);
    chk("rst_wdata_64",    wdata_b, 0);
    chk("rst_done_64",     64'(done_b), 0);
    reset = 0; chk_en = 1;
    @(posedge clock); #1;

    // 32-bit big-endian signed byte load, ack in the 2nd wait cycle
    txn(0, 0, 2'd0, 1, 1, 0, 32'h1003, 64'h0, 2, 64'h1122_33F0);
    chk("lit_be_byte_addr",  obs_addr,  64'h1000);
    chk("lit_be_byte_strb",  obs_strb,  64'h0);
    chk("lit_be_byte_rdata", obs_rdata, 64'hFFFF_FFF0);
    chk("lit_be_byte_reqs",  64'(req_cycles), 64'd2);

    // 64-bit little-endian half store at 0x06
    txn(1, 1, 2'd1, 0, 0, 0, 32'h6, 64'hABCD, 1, 64'h0);
    chk("lit_le_half_strb",  obs_strb,  64'hC0);
    chk("lit_le_half_wdata", obs_wdata, 64'hABCD_ABCD_ABCD_ABCD);
    chk("lit_le_half_addr",  obs_addr,  64'h0);

    // address errors: misaligned word load, dword on 32-bit, misaligned half store
    txn(0, 0, 2'd2, 0, 0, 0, 32'h2, 64'h0, 1, 64'h0);
    chk("lit_word_mis_adel",  64'(obs_adel), 64'd1);
    chk("lit_word_mis_noreq", 64'(req_cycles), 64'd0);
    txn(0, 0, 2'd3, 0, 0, 0, 32'h0, 64'h0, 1, 64'h0);
    chk("lit_dword32_adel", 64'(obs_adel), 64'd1);
    txn(0, 1, 2'd1, 0, 0, 0, 32'h1, 64'h1234, 1, 64'h0);
    chk("lit_half_mis_ades", 64'(obs_ades), 64'd1);

    // bus timeout on the 32-bit unit, then a late ack that must be ignored
    txn(0, 0, 2'd2, 0, 0, 0, 32'h40, 64'h0, 0, 64'h0);
    chk("lit_timeout_reqs",   64'(req_cycles), 64'd4);
    chk("lit_timeout_buserr", 64'(obs_berr), 64'd1);
    mem_ack = 1; mem_rdata = 64'hFFFF_FFFF;
    @(posedge clock); #1;
    mem_ack = 0;
    repeat (2) @(posedge clock);
    #1;

    // 64-bit loads: BE dword, LE signed word in upper half, BE unsigned byte
    txn(1, 0, 2'd3, 0, 1, 0, 32'h8, 64'h0, 3, 64'h8877_6655_4433_2211);
    chk("lit_dword_rdata", obs_rdata, 64'h8877_6655_4433_2211);
    txn(1, 0, 2'd2, 1, 0, 0, 32'h4, 64'h0, 1, 64'h8000_0000_1234_5678);
    chk("lit_word64_sext", obs_rdata, 64'hFFFF_FFFF_8000_0000);
    txn(1, 0, 2'd0, 0, 1, 0, 32'h0, 64'h0, 1, 64'hA500_0000_0000_0011);
    chk("lit_be_byte64", obs_rdata, 64'hA5);

    // 32-bit stores and a BE half load with clear sign bit
    txn(0, 1, 2'd2, 0, 0, 0, 32'h10, 64'hDEAD_BEEF, 1, 64'h0);
    chk("lit_word_st_strb",  obs_strb,  64'hF);
    chk("lit_word_st_wdata", obs_wdata, 64'hDEAD_BEEF);
    txn(0, 1, 2'd0, 0, 1, 0, 32'h21, 64'h5A, 2, 64'h0);
    chk("lit_be_byte_st_strb",  obs_strb,  64'h4);
    chk("lit_be_byte_st_wdata", obs_wdata, 64'h5A5A_5A5A);
    txn(0, 0, 2'd1, 1, 1, 0, 32'h2, 64'h0, 1, 64'h8001_7FFF);
    chk("lit_be_half_rdata", obs_rdata, 64'h7FFF);

`ifdef MEM_ACCESS_LLSC_EN
    // LL then SC to the same line succeeds
    txn(0, 0, 2'd2, 0, 0, 1, 32'h100, 64'h0, 1, 64'h1234);
    txn(0, 1, 2'd2, 0, 0, 1, 32'h100, 64'h77, 1, 64'h0);
    chk("lit_sc_ok_rdata", obs_rdata, 64'd1);
    chk("lit_sc_ok_reqs",  64'(req_cycles), 64'd1);
    // LL, ERET clear, SC fails without a bus access
    txn(0, 0, 2'd2, 0, 0, 1, 32'h100, 64'h0, 1, 64'h1234);
    clear_resv = 1;
    @(posedge clock); #1;
    clear_resv = 0; resv_v = 0;
    txn(0, 1, 2'd2, 0, 0, 1, 32'h100, 64'h77, 1, 64'h0);
    chk("lit_sc_clr_rdata", obs_rdata, 64'd0);
    chk("lit_sc_clr_reqs",  64'(req_cycles), 64'd0);
    // LL, plain store to the same line, SC fails
    txn(0, 0, 2'd2, 0, 0, 1, 32'h100, 64'h0, 1, 64'h1234);
    txn(0, 1, 2'd1, 0, 0, 0, 32'h102, 64'h55, 1, 64'h0);
    txn(0, 1, 2'd2, 0, 0, 1, 32'h100, 64'h77, 1, 64'h0);
    chk("lit_sc_st_rdata", obs_rdata, 64'd0);
    // clear_resv coincident with the LL ack wins
    clr_at_ack = 1;
    txn(0, 0, 2'd2, 0, 0, 1, 32'h100, 64'h0, 1, 64'h1234);
    clr_at_ack = 0;
    txn(0, 1, 2'd2, 0, 0, 1, 32'h100, 64'h77, 1, 64'h0);
    chk("lit_sc_prio_reqs", 64'(req_cycles), 64'd0);
`else
    // without reservation tracking SC is a plain store and LL a plain load
    txn(0, 1, 2'd2, 0, 0, 1, 32'h100, 64'h77, 1, 64'h0);
    chk("lit_sc_plain_rdata", obs_rdata, 64'd0);
    chk("lit_sc_plain_reqs",  64'(req_cycles), 64'd1);
    chk("lit_sc_plain_strb",  obs_strb, 64'hF);
    txn(0, 0, 2'd2, 0, 0, 1, 32'h100, 64'h0, 2, 64'h9ABC);
    chk("lit_ll_plain_rdata", obs_rdata, 64'h9ABC);
`endif

    // reset while waiting for ack: request drops, no completion, late ack ignored
    sel = 0; cpu_we = 0; cpu_size = 2'd2; cpu_addr = 32'h40; cpu_be = 0; cpu_sign = 0;
    cpu_llsc = 0; cpu_wdata = 64'h0; cpu_req = 1;
    @(posedge clock); #1;
    exp_mreq = 1; exp_we = 0; exp_addr = 64'h40; exp_strb = 64'h0; exp_wdata = 64'h0;
    @(posedge clock); #1;
    reset = 1; cpu_req = 0;
    @(posedge clock); #1;
    set_idle(); resv_v = 0;
    chk("lit_rst_wait_mreq", 64'(mreq_a), 64'd0);
    reset = 0;
    mem_ack = 1; mem_rdata = 64'h1;
    @(posedge clock); #1;
    mem_ack = 0;
    repeat (2) @(posedge clock);
    #1;
    txn(0, 0, 2'd2, 0, 0, 0, 32'h44, 64'h0, 1, 64'hCAFE_F00D);
    chk("lit_after_rst_rdata", obs_rdata, 64'hCAFE_F00D);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised data-memory access unit for the MEM stage. It converts CPU load/store requests into aligned full-width memory transactions with per-byte strobes. Supported sizes are byte, half, word and (when DATA_W=64) doubleword, in either endianness. Unlike the current controller, it adds a request/ack FSM with a bus-timeout counter and configurable data and address widths; LL/SC reservation tracking is an optional feature.

Parameters:
DATA_W, 32, memory/CPU data width; 32 or 64 only.
ADDR_W, 32, byte address width.
TIMEOUT_CYC, 16, max cycles waiting for mem_ack; 0 disables the timeout.

Ports:
clock  in  1  clock
reset  in  1  reset
cpu_req  in  1  request; held with all cpu_* inputs stable until cpu_done
cpu_we  in  1  1=store, 0=load
cpu_size  in  2  0=byte 1=half 2=word 3=dword
cpu_sign  in  1  sign-extend sub-width loads
cpu_be  in  1  1=big endian, 0=little endian
cpu_llsc  in  1  LL (load) / SC (store)
clear_resv  in  1  ERET: clear the LL reservation
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  DATA_W  store data, right-justified
cpu_rdata  out  DATA_W  load result, or SC status
cpu_done  out  1  one-cycle completion pulse
cpu_adel  out  1  load address error, valid with cpu_done
cpu_ades  out  1  store address error, valid with cpu_done
cpu_buserr  out  1  timeout, valid with cpu_done
mem_req  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  ADDR_W  address with low log2(DATA_W/8) bits zeroed
mem_wstrb  out  DATA_W/8  byte strobes; bit i = bits [8i+7:8i]
mem_wdata  out  DATA_W  replicated write data
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_ack  in  1  memory completion

Behaviour:
- Reset: reset, synchronous, active-high; clock clock. On reset: state IDLE; all outputs 0; reservation invalid; timeout counter 0.
- Reset mid-transaction aborts it with no cpu_done; a late mem_ack arriving afterwards is ignored.
- Lane mapping: NB=DATA_W/8; off=cpu_addr[log2 NB-1:0]; n=1<<cpu_size.
  - Little endian: lanes off..off+n-1.
  - Big endian: lanes NB-off-n..NB-1-off.
- Address error when any of:
  - off is not a multiple of n;
  - cpu_size=3 with DATA_W=32.
- mem_wdata: the low n bytes of cpu_wdata, replicated across all lanes.
- Load result: selected lanes, right-justified, then zero- or sign-extended to DATA_W. A word load on a 64-bit bus also extends.
- FSM states: IDLE, WAIT, RESP.
- IDLE with cpu_req:
  - Address error → RESP, with cpu_adel or cpu_ades set.
  - SC that fails the reservation check → RESP, cpu_rdata=0, no memory access.
  - Otherwise → WAIT. On the same edge, register mem_req=1, mem_we, mem_addr, mem_wstrb (all zero for loads) and mem_wdata.
- WAIT:
  - mem_ack=1: drop mem_req, capture and format mem_rdata → RESP. A successful SC returns cpu_rdata=1.
  - Timeout counter reaches TIMEOUT_CYC-1 with no ack: drop mem_req → RESP, cpu_buserr=1.
- RESP: cpu_done=1 and the result/exception flags are driven for exactly one cycle → IDLE.
- Error flags and cpu_rdata return to 0 outside RESP.
- Latency: mem_req asserts one cycle after cpu_req is sampled; cpu_done asserts one cycle after mem_ack. The earliest repeat request is accepted the cycle after cpu_done.
- mem_ack outside WAIT is ignored.
- cpu_req is sampled only in IDLE.

Optional Feature:
Macro MEM_ACCESS_LLSC_EN.
- Defined:
  - A reservation (valid bit plus line address cpu_addr[ADDR_W-1:log2 NB]) is set when an LL completes with ack.
  - It is cleared by clear_resv, by any acked store whose line matches, or by reset.
  - clear_resv takes priority over a simultaneous LL set.
  - SC succeeds only if the reservation is valid and the line matches; a successful SC clears the reservation.
- Undefined: cpu_llsc is ignored, so LL behaves as a plain load and SC as a plain store; cpu_rdata is 0 on stores; no reservation state exists.

Test Plan:
- DATA_W=32, big endian, byte load at addr 0x1003, sign=1, mem_rdata=0x112233F0, ack after 2 cycles → mem_addr=0x1000, mem_wstrb=0, cpu_rdata=0xFFFFFFF0, cpu_done one cycle after ack.
- DATA_W=64, little endian, half store of 0xABCD at addr 0x06 → mem_wstrb=0xC0, mem_wdata=0xABCD replicated ×4, cpu_done after ack.
- Word load at addr 0x2 → no mem_req; cpu_done with cpu_adel=1 two cycles after cpu_req. Dword request with DATA_W=32 → cpu_adel=1.
- TIMEOUT_CYC=4, no ack → mem_req high for exactly 4 cycles, then cpu_done with cpu_buserr=1. A late ack has no effect.
- LLSC_EN: LL at 0x100; SC at 0x100 → write performed, cpu_rdata=1. LL; clear_resv; SC → no mem_req, cpu_rdata=0. LL 0x100; store to 0x102; SC → cpu_rdata=0.
- Assert reset in WAIT → mem_req=0 next cycle, no cpu_done. A fresh request then completes normally.
